// File: rtl/arb8_rr.sv
// rtl/arb8_rr.sv - 8-way round-robin arbiter with per-requester burst lock driving a downstream 8:1 mux select.
module arb8_rr #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] lock,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] sel,
    output logic [7:0] grant
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    grant_q, grant_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    logic [2:0] rot_ptr;
    logic [3:0] pick_idle;
    logic [3:0] pick_rot;

    // Returns {found, index} of the first set request at or after p, wrapping.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        bcnt_d    = bcnt_q;
        rot_ptr   = sel_q + 3'd1;
        pick_idle = rr_pick(req, ptr_q);
        pick_rot  = rr_pick(req, rot_ptr);

        case (state_q)
            IDLE: begin
                if (pick_idle[3]) begin
                    state_d = BUSY;
                    sel_d   = pick_idle[2:0];
                    bcnt_d  = '0;
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (lock[sel_q] && (bcnt_q < BLAST)) begin
                        bcnt_d = bcnt_q + BW'(1);
                    end else begin
                        // Rotation puts the just-served requester last in line.
                        ptr_d  = rot_ptr;
                        bcnt_d = '0;
                        if (pick_rot[3]) begin
                            sel_d = pick_rot[2:0];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = (state_d == BUSY) ? (8'b1 << sel_d) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            grant_q <= 8'h00;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign out_valid = (state_q == BUSY);
    assign sel       = sel_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_arb8_rr.sv
// tb/tb_arb8_rr.sv - scoreboard bench for arb8_rr: directed scenarios plus randomized traffic.
module tb_arb8_rr;

    localparam int MB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] lock;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] sel;
    logic [7:0] grant;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic       valid;
        logic [2:0] sel;
        logic [7:0] grant;
    } exp_t;

    exp_t sb[$];

    logic       m_valid;
    logic [2:0] m_sel;
    logic [2:0] m_ptr;
    int         m_bcnt;

    arb8_rr #(.MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .sel       (sel),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Independent search: walk from the start pointer until a request is found.
    task automatic find_first(input logic [7:0] r, input logic [2:0] start,
                              output logic found, output logic [2:0] who);
        logic [2:0] p;
        found = 1'b0;
        who   = 3'd0;
        p     = start;
        repeat (8) begin
            if (!found && r[p]) begin
                found = 1'b1;
                who   = p;
            end
            p = p + 3'd1;
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] rq, input logic [7:0] lk,
                              input logic rdy);
        logic       f;
        logic [2:0] w;
        exp_t       e;
        if (r) begin
            m_valid = 1'b0;
            m_sel   = 3'd0;
            m_ptr   = 3'd0;
            m_bcnt  = 0;
        end else if (!m_valid) begin
            find_first(rq, m_ptr, f, w);
            if (f) begin
                m_valid = 1'b1;
                m_sel   = w;
                m_bcnt  = 0;
            end
        end else if (!rq[m_sel]) begin
            m_valid = 1'b0;
        end else if (rdy) begin
            if (lk[m_sel] && m_bcnt < MB - 1) begin
                m_bcnt = m_bcnt + 1;
            end else begin
                m_ptr  = m_sel + 3'd1;
                m_bcnt = 0;
                find_first(rq, m_ptr, f, w);
                if (f) m_sel = w;
                else   m_valid = 1'b0;
            end
        end
        e.valid = m_valid;
        e.sel   = m_sel;
        e.grant = m_valid ? (8'h01 << m_sel) : 8'h00;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] lk,
                        input logic rdy);
        exp_t e;
        rst       = r;
        req       = rq;
        lock      = lk;
        out_ready = rdy;
        model_step(r, rq, lk, rdy);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("valid", {31'd0, out_valid}, {31'd0, e.valid});
            check("grant", {24'd0, grant}, {24'd0, e.grant});
            if (e.valid) check("sel", {29'd0, sel}, {29'd0, e.sel});
        end
        check("onehot", {31'd0, ($countones(grant) > 1)}, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        step(1'b1, 8'h5A, 8'h00, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_valid = 1'b0;
        m_sel   = 3'd0;
        m_ptr   = 3'd0;
        m_bcnt  = 0;
        rst = 1'b1; req = 8'h00; lock = 8'h00; out_ready = 1'b0;

        do_reset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_grant", {24'd0, grant}, 32'd0);

        // Two requesters at the extremes alternate.
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 8'h81, 8'h00, 1'b1);
            check("r025_sel", {29'd0, sel}, (k % 2) ? 32'd7 : 32'd0);
            check("r025_grant", {24'd0, grant}, (k % 2) ? 32'h80 : 32'h01);
        end

        // Full request vector walks 0..7 and wraps with no bubbles.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 8'hFF, 8'h00, 1'b1);
            check("r026_sel", {29'd0, sel}, 32'(k % 8));
            check("r026_valid", {31'd0, out_valid}, 32'd1);
        end

        // Locked burst capped at MB transfers.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'h05, 8'h01, 1'b1);
            check("r027_sel", {29'd0, sel}, ((k % 5) == 4) ? 32'd2 : 32'd0);
        end

        // Stall holds the grant, release rotates.
        do_reset();
        step(1'b0, 8'h08, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'hFF, 8'h00, 1'b0);
            check("r028_hold_sel", {29'd0, sel}, 32'd3);
            check("r028_hold_grant", {24'd0, grant}, 32'h08);
        end
        step(1'b0, 8'hFF, 8'h00, 1'b1);
        check("r028_next_sel", {29'd0, sel}, 32'd4);

        // Withdrawal during stall drops to idle with pointer kept at 5.
        do_reset();
        step(1'b0, 8'h10, 8'h00, 1'b1);
        step(1'b0, 8'h30, 8'h00, 1'b1);
        check("r029_sel5", {29'd0, sel}, 32'd5);
        step(1'b0, 8'h20, 8'h00, 1'b0);
        step(1'b0, 8'h41, 8'h00, 1'b0);
        check("r029_idle_valid", {31'd0, out_valid}, 32'd0);
        check("r029_idle_grant", {24'd0, grant}, 32'd0);
        step(1'b0, 8'h41, 8'h00, 1'b0);
        check("r029_rearb_sel", {29'd0, sel}, 32'd6);

        // Reset mid-burst aborts the grant.
        do_reset();
        step(1'b0, 8'h04, 8'h04, 1'b1);
        step(1'b0, 8'h04, 8'h04, 1'b1);
        step(1'b0, 8'h04, 8'h04, 1'b1);
        step(1'b1, 8'h04, 8'h04, 1'b1);
        check("r030_rst_valid", {31'd0, out_valid}, 32'd0);
        check("r030_rst_sel", {29'd0, sel}, 32'd0);
        check("r030_rst_grant", {24'd0, grant}, 32'd0);
        step(1'b0, 8'h04, 8'h00, 1'b1);
        check("r030_after_sel", {29'd0, sel}, 32'd2);

        // Randomized traffic, all checked against the model.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] rq;
            rq = ($urandom_range(0, 1) == 1) ? 8'($urandom & $urandom) : 8'($urandom);
            step(($urandom_range(0, 39) == 0), rq, 8'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
